// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared data width, FSM state codes and saturating subtract for the peak-hold block
package spectrum_pkg;
    localparam int LOG_W = 8;
    typedef logic [1:0] state_t;
    localparam state_t CLEAR = 2'd0;
    localparam state_t SYNC  = 2'd1;
    localparam state_t ACCUM = 2'd2;
    function automatic logic [LOG_W-1:0] sat_sub(input logic [LOG_W-1:0] a, input logic [LOG_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction
endpackage

// File: rtl/spectrum_bar_ram.sv
// spectrum_bar_ram: bar-height store with one write port and two registered read-first read ports
module spectrum_bar_ram
    import spectrum_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    input  logic [LOG_W-1:0] wd_i,
    input  logic [AW-1:0]    ra_a_i,
    output logic [LOG_W-1:0] rd_a_o,
    input  logic [AW-1:0]    ra_b_i,
    output logic [LOG_W-1:0] rd_b_o
);
    logic [LOG_W-1:0] mem_q [DEPTH];
    // Array contents are initialised by the owner's clear sweep, so the array itself has no reset
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wa_i] <= wd_i;
    end
    // Both reads sample the array before this cycle's write lands, giving read-first behaviour
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_a_o <= '0;
            rd_b_o <= '0;
        end else begin
            rd_a_o <= mem_q[ra_a_i];
            rd_b_o <= mem_q[ra_b_i];
        end
    end
endmodule

// File: rtl/spectrum_peak_hold.sv
// spectrum_peak_hold: per-bar max of FFT log bins with peak hold; SPECTRUM_PEAK_DECAY_EN enables hold+decay
module spectrum_peak_hold
    import spectrum_pkg::*;
#(
    parameter int NUM_BINS   = 512,
    parameter int NUM_BARS   = 64,
    parameter int DECAY_STEP = 2,
    parameter int DECAY_DIV  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LOG_W-1:0]            log_in,
    input  logic                        log_valid,
    input  logic                        log_last,
    input  logic [$clog2(NUM_BARS)-1:0] rd_addr,
    output logic [LOG_W-1:0]            rd_data,
    output logic                        frame_done,
    output logic                        frame_err
);
    localparam int BPB   = NUM_BINS / NUM_BARS;
    localparam int BIN_W = $clog2(NUM_BINS);
    localparam int BAR_W = $clog2(NUM_BARS);
    localparam int GRP_W = $clog2(BPB);

    if (NUM_BARS < 2 || (NUM_BINS & (NUM_BINS - 1)) != 0 || (NUM_BARS & (NUM_BARS - 1)) != 0 ||
        NUM_BINS % NUM_BARS != 0 || BPB < 2 || DECAY_DIV < 1 || DECAY_STEP < 0 ||
        DECAY_STEP >= 2 ** LOG_W) begin : g_bad_cfg
        $error("spectrum_peak_hold: illegal NUM_BINS/NUM_BARS/DECAY_STEP/DECAY_DIV combination");
    end

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_cnt_q, bin_cnt_d;
    logic [LOG_W-1:0]   grp_max_q;
    logic               wr_pend_q, wr_done_q;
    logic [BAR_W-1:0]   wr_addr_q;
    logic               frame_done_q, frame_err_q;
    logic [LOG_W-1:0]   rmw_data, wr_val, cur_max;
    logic [BAR_W-1:0]   bar_idx;
    logic               acc, grp_first, grp_last, at_end, clr_last, good, short_f, long_f;
    logic               clearing;

    assign clearing  = state_q == CLEAR;
    assign acc       = (state_q == ACCUM) && log_valid;
    assign bar_idx   = bin_cnt_q[BIN_W-1:GRP_W];
    assign grp_first = ~|bin_cnt_q[GRP_W-1:0];
    assign grp_last  = &bin_cnt_q[GRP_W-1:0];
    assign at_end    = &bin_cnt_q;
    assign clr_last  = bin_cnt_q == BIN_W'(NUM_BARS - 1);
    assign good      = acc && log_last && at_end;
    assign short_f   = acc && log_last && !at_end;
    assign long_f    = acc && !log_last && at_end;
    assign cur_max   = (grp_first || log_in > grp_max_q) ? log_in : grp_max_q;

`ifdef SPECTRUM_PEAK_DECAY_EN
    localparam int DCW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    logic [DCW-1:0]   dcnt_q;
    logic             wr_dec_q, dec_frame;
    logic [LOG_W-1:0] held;
    assign dec_frame = dcnt_q == DCW'(DECAY_DIV - 1);
    assign held      = sat_sub(rmw_data, wr_dec_q ? LOG_W'(DECAY_STEP) : '0);
    assign wr_val    = (grp_max_q > held) ? grp_max_q : held;
    // Decay flag travels with each pending write so the frame-end counter bump cannot affect it
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q   <= '0;
            wr_dec_q <= 1'b0;
        end else begin
            dcnt_q   <= good ? (dec_frame ? '0 : dcnt_q + 1'b1) : dcnt_q;
            wr_dec_q <= dec_frame;
        end
    end
`else
    logic unused_rmw;
    assign unused_rmw = ^rmw_data;
    assign wr_val     = grp_max_q;
`endif

    // Frame sequencing: clear sweep, resync to a frame boundary, then count bins
    always_comb begin
        state_d   = state_q;
        bin_cnt_d = bin_cnt_q;
        if (state_q == CLEAR) begin
            state_d   = clr_last ? SYNC : CLEAR;
            bin_cnt_d = clr_last ? '0 : bin_cnt_q + 1'b1;
        end else if (state_q == SYNC) begin
            state_d   = (log_valid && log_last) ? ACCUM : SYNC;
            bin_cnt_d = '0;
        end else if (state_q != ACCUM) begin
            state_d   = CLEAR;
            bin_cnt_d = '0;
        end else if (log_valid) begin
            state_d   = long_f ? SYNC : ACCUM;
            bin_cnt_d = log_last ? '0 : bin_cnt_q + 1'b1;
        end
    end

    // Group max, the one-cycle-deferred bar write and the frame status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            bin_cnt_q    <= '0;
            grp_max_q    <= '0;
            wr_pend_q    <= 1'b0;
            wr_done_q    <= 1'b0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_cnt_q    <= bin_cnt_d;
            grp_max_q    <= acc ? cur_max : grp_max_q;
            wr_pend_q    <= acc && grp_last;
            wr_done_q    <= good;
            wr_addr_q    <= bar_idx;
            frame_done_q <= wr_pend_q && wr_done_q;
            frame_err_q  <= short_f || long_f;
        end
    end

    spectrum_bar_ram #(.DEPTH(NUM_BARS)) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we_i   (clearing || wr_pend_q),
        .wa_i   (clearing ? bin_cnt_q[BAR_W-1:0] : wr_addr_q),
        .wd_i   (clearing ? '0 : wr_val),
        .ra_a_i (bar_idx),
        .rd_a_o (rmw_data),
        .ra_b_i (rd_addr),
        .rd_b_o (rd_data)
    );

    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_spectrum_peak_hold.sv
// tb_spectrum_peak_hold: randomized scoreboard bench for spectrum_peak_hold (honours SPECTRUM_PEAK_DECAY_EN)
module tb_spectrum_peak_hold;
    localparam int NB = 16, NR = 4, BPB = 4, STEP = 2, DIV = 2;
`ifdef SPECTRUM_PEAK_DECAY_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] log_in = '0;
    logic log_valid = 1'b0, log_last = 1'b0;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic frame_done, frame_err;

    spectrum_peak_hold #(.NUM_BINS(NB), .NUM_BARS(NR), .DECAY_STEP(STEP), .DECAY_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .log_in(log_in), .log_valid(log_valid), .log_last(log_last),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; int at;} ev_t;
    ev_t evq[$];
    int  rdq[$];
    int  checks = 0, errors = 0, cyc = 0, exp_rd = 0;
    logic rd_req = 1'b0, rd_req_q = 1'b0;
    int  bars[NR];
    int  dcnt = 0, idx = 0, gm = 0;
    bit  syncing = 1'b1;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_q <= rd_req;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected %s pulse at cycle %0d", kind == 1 ? "frame_done" : "frame_err", cyc);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                errors++;
                $display("FAIL event: got kind %0d at cycle %0d expected kind %0d at cycle %0d", kind, cyc, e.kind, e.at);
            end
        end
    endtask

    // Monitor: compares display reads and status pulses against the scoreboard queues
    always @(negedge clk) begin
        if (rd_req_q) begin
            if (rdq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data: unexpected read response %0d", rd_data);
            end else begin
                exp_rd = rdq.pop_front();
                chk("rd_data", int'(rd_data), exp_rd);
            end
        end
        if (frame_done) check_ev(1);
        if (frame_err) check_ev(2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: frame-level bar update rules
    task automatic model(input int v, input bit last);
        int dec, held, b;
        if (syncing) begin
            if (last) begin
                syncing = 1'b0;
                idx = 0;
            end
            return;
        end
        gm = (idx % BPB == 0 || v > gm) ? v : gm;
        if (idx % BPB == BPB - 1) begin
            b    = idx / BPB;
            dec  = (dcnt == DIV - 1) ? STEP : 0;
            held = HOLD ? ((bars[b] > dec) ? bars[b] - dec : 0) : 0;
            bars[b] = (gm > held) ? gm : held;
        end
        if (last) begin
            if (idx == NB - 1) begin
                evq.push_back('{kind: 1, at: cyc + 2});
                dcnt = (dcnt + 1) % DIV;
            end else evq.push_back('{kind: 2, at: cyc + 1});
            idx = 0;
        end else if (idx == NB - 1) begin
            evq.push_back('{kind: 2, at: cyc + 1});
            syncing = 1'b1;
            idx = 0;
        end else idx++;
    endtask

    task automatic model_reset();
        foreach (bars[i]) bars[i] = 0;
        dcnt = 0;
        idx = 0;
        syncing = 1'b1;
    endtask

    task automatic send(input int v, input bit last);
        log_valid = 1'b1;
        log_in    = 8'(v);
        log_last  = last;
        model(v, last);
        tick();
        log_valid = 1'b0;
        log_in    = 8'($urandom);
        log_last  = 1'($urandom);
        if ($urandom_range(0, 3) == 0) tick();
    endtask

    // mode 0: random, 1: ramp 10,20,..., 2: all zero
    task automatic send_frame(input int n, input bit with_last, input int mode);
        for (int i = 0; i < n; i++)
            send(mode == 1 ? 10 * (i + 1) : mode == 2 ? 0 : int'($urandom_range(0, 255)), with_last && i == n - 1);
    endtask

    task automatic read_all();
        repeat (4) tick();
        for (int a = 0; a < NR; a++) begin
            rd_addr = 2'(a);
            rd_req  = 1'b1;
            rdq.push_back(bars[a]);
            tick();
            rd_req = 1'b0;
            tick();
        end
        tick();
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        @(negedge clk);
        chk("reset rd_data", int'(rd_data), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset frame_err", int'(frame_err), 0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        read_all();
        send_frame(NB, 1'b1, 0);
        send_frame(NB, 1'b1, 1);
        read_all();
        repeat (4) begin
            send_frame(NB, 1'b1, 2);
            read_all();
        end
        send_frame(10, 1'b1, 0);
        read_all();
        send_frame(NB, 1'b1, 0);
        read_all();
        send_frame(20, 1'b0, 0);
        send($urandom_range(0, 255), 1'b1);
        send_frame(NB, 1'b1, 0);
        read_all();
        repeat (3) begin
            send_frame(NB, 1'b1, 0);
            read_all();
        end
        send_frame(NB, 1'b1, 1);
        read_all();
        send_frame(8, 1'b0, 0);
        rst = 1'b1;
        model_reset();
        tick();
        @(negedge clk);
        chk("midreset rd_data", int'(rd_data), 0);
        chk("midreset frame_done", int'(frame_done), 0);
        chk("midreset frame_err", int'(frame_err), 0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        read_all();
        send_frame(NB, 1'b1, 0);
        send_frame(NB, 1'b1, 0);
        read_all();
        repeat (6) tick();
        chk("pending events", evq.size(), 0);
        chk("pending reads", rdq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
